// File: rtl/seq_player_if.sv
// rtl/seq_player_if.sv - playback request/response and LED output bundle for seq_player
interface seq_player_if #(
    parameter int N  = 64,
    parameter int N1 = 4
);
    logic          start_i;
    logic          stop_i;
    logic [N-1:0]  seq_i;
    logic [4:0]    len_i;
    logic [N1-1:0] led_o;
    logic [3:0]    idx_o;
    logic          busy_o;
    logic          done_o;

    modport master (
        output start_i, stop_i, seq_i, len_i,
        input  led_o, idx_o, busy_o, done_o
    );

    modport slave (
        input  start_i, stop_i, seq_i, len_i,
        output led_o, idx_o, busy_o, done_o
    );
endinterface

// File: rtl/seq_player.sv
// rtl/seq_player.sv - plays the first len entries of a captured sequence word on the LEDs
module seq_player #(
    parameter int N       = 64,
    parameter int N1      = 4,
    parameter int ON_CYC  = 4,
    parameter int OFF_CYC = 2
) (
    input  logic          clk_i,
    input  logic          r_n_i,
    seq_player_if.slave   bus
);
    localparam int TMAX = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ON,
        ST_OFF,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    idx_q, idx_d;
    logic [4:0]    len_q, len_d;
    logic [N-1:0]  shadow_q, shadow_d;
    logic [N1-1:0] led_q, led_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [4:0]    len_clamped;
    logic [N-1:0]  entry_word;

    assign len_clamped = (bus.len_i > 5'd16) ? 5'd16 : bus.len_i;

    always_ff @(posedge clk_i or negedge r_n_i) begin
        if (!r_n_i) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            idx_q    <= '0;
            len_q    <= '0;
            shadow_q <= '0;
            led_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            shadow_q <= shadow_d;
            led_q    <= led_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        idx_d      = idx_q;
        len_d      = len_q;
        shadow_d   = shadow_q;
        led_d      = '0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        entry_word = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    shadow_d = bus.seq_i;
                    len_d    = len_clamped;
                    idx_d    = '0;
                    timer_d  = '0;
                    state_d  = (len_clamped == 5'd0) ? ST_DONE : ST_ON;
                end
            end
            ST_ON: begin
                if (timer_q == TW'(ON_CYC - 1)) begin
                    timer_d = '0;
                    state_d = ST_OFF;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_OFF: begin
                if (timer_q == TW'(OFF_CYC - 1)) begin
                    timer_d = '0;
                    // 5-bit compare so len=16 finishes on idx 15 without wrapping
                    if ({1'b0, idx_q} == len_q - 5'd1) begin
                        idx_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_ON;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_DONE: begin
                idx_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.stop_i) begin
            state_d = ST_IDLE;
            timer_d = '0;
            idx_d   = '0;
        end

        // Outputs are registered copies of what the next state presents
        entry_word = shadow_d << (N1 * idx_d);
        busy_d     = (state_d == ST_ON) || (state_d == ST_OFF);
        done_d     = (state_d == ST_DONE);
        if (state_d == ST_ON) begin
            led_d = entry_word[N-1 -: N1];
        end
    end

    assign bus.led_o  = led_q;
    assign bus.idx_o  = idx_q;
    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;
endmodule

// File: doc/seq_player.md
Name: seq_player

Overview:
- Reads back a 64-bit colour sequence word held by the game's sequence register and plays it on the four LEDs, one nibble per step.
- Sits between the sequence register output and the LED driver. It is the consumer/reader side of that register.
- The game FSM starts a playback of the first len_i entries and waits for done_o before accepting player input.

Parameters:
N, 64, sequence word width
N1, 4, entry width (one-hot LED code)
ON_CYC, 4, cycles each entry is lit (>=1)
OFF_CYC, 2, blank cycles after each entry (>=1)

Ports:
clk_i  input  1  clock, all state updates on rising edge
r_n_i  input  1  asynchronous active-low reset
start_i  input  1  playback request, sampled only in IDLE
stop_i  input  1  synchronous abort, any state
seq_i  input  N  sequence word; entry k = seq_i[N-1-N1*k -: N1], entry 0 = [63:60]
len_i  input  5  entries to play, 0..16; values >16 clamp to 16
led_o  output  N1  current LED pattern
idx_o  output  4  index of entry being played
busy_o  output  1  high while playback in progress
done_o  output  1  one-cycle pulse at playback completion

Behaviour:
- Reset is one clock, asynchronous, active-low. While r_n_i=0:
  - state=IDLE
  - led_o=0, idx_o=0, busy_o=0, done_o=0
  - internal seq copy, length and timer all cleared
  - reset mid-playback aborts immediately with no done_o.
- States: IDLE, ON, OFF, DONE. All outputs are registered.
- IDLE:
  - start_i=1 and stop_i=0 at an edge: capture seq_i into a shadow register, capture clamp(len_i), idx=0, timer=0.
  - If the captured length is 0, go to DONE. Otherwise go to ON.
  - Later changes to seq_i/len_i do not affect an ongoing playback.
- ON:
  - busy_o=1, led_o = shadow entry idx, idx_o=idx.
  - Timer counts 0..ON_CYC-1. At ON_CYC-1, timer=0 and go to OFF.
- OFF:
  - busy_o=1, led_o=0, idx_o holds.
  - Timer counts 0..OFF_CYC-1. At OFF_CYC-1, timer=0.
  - If idx=len-1, go to DONE. Otherwise idx+1 and go to ON.
- DONE:
  - Lasts exactly one cycle: done_o=1, busy_o=0, led_o=0, idx_o=0.
  - Then go to IDLE. start_i is ignored in DONE.
- stop_i=1 at any edge has priority over everything except reset:
  - go to IDLE, clear led_o/idx_o/timer/busy_o.
  - No done_o pulse.
  - start_i on the same edge is ignored.
- start_i while busy is ignored. No queueing.
- Timing: start sampled at edge E.
  - busy_o is high from E+1 for len*(ON_CYC+OFF_CYC) cycles.
  - done_o is high in the following cycle.
  - For len=0, done_o is high in cycle E+1 and busy_o never rises.
- Widths: timer is wide enough for max(ON_CYC,OFF_CYC)-1. idx is 4 bits. The len compare uses 5 bits, so len=16 ends at idx=15 with no wrap.
- led_o values are passed through unmodified. Non-one-hot nibbles are not checked.

Test Plan:
- seq_i=64'h1248_0000_0000_0000, len_i=4, ON=4, OFF=2, start at edge 0 -> led_o: 1 (cycles 1-4), 0 (5-6), 2 (7-10), 0 (11-12), 4 (13-16), 0 (17-18), 8 (19-22), 0 (23-24); busy_o over cycles 1-24; done_o=1 only in cycle 25; idx_o steps 0,1,2,3.
- len_i=0 start -> done_o pulse in cycle 1, busy_o and led_o stay 0; len_i=20 with seq_i=64'h1111_..._1118 -> 16 entries played, last led_o=8 at idx_o=15, done_o after 96 busy cycles.
- seq_i changed to all-zero at cycle 3 of a len=4 playback of 64'h1248_... -> played values still 1,2,4,8.
- stop_i at cycle 8 of a len=4 playback -> cycle 9: IDLE, led_o=0, busy_o=0, idx_o=0, no done_o; start_i at cycle 5 during playback -> ignored, single done_o at cycle 25.
- r_n_i low for 1 cycle at cycle 10 mid-playback -> outputs zero immediately (asynchronously); new start after release plays entry 0 from scratch.
- start_i held high continuously with len=1 -> pattern repeats: busy 6 cycles, done 1 cycle, IDLE 1 cycle (restart sampled), period 8 cycles.
